logicnet_input_quantizer: RTL

//  Front end of the LogicNet classifier. Accepts raw signed feature words one per beat,

---
 rtl/lnet_pkg.sv | 17 +
 rtl/logicnet_input_quantizer_if.sv | 22 ++
 rtl/lnet_thresh_quant.sv | 21 ++
 rtl/logicnet_input_quantizer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/lnet_pkg.sv
// Shared types and constants for the LogicNet input quantizer.
package lnet_pkg;

  localparam int CODE_W = 2;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam logic [CODE_W-1:0] Q_LO = 2'b00;
  localparam logic [CODE_W-1:0] Q_ML = 2'b01;
  localparam logic [CODE_W-1:0] Q_MH = 2'b10;
  localparam logic [CODE_W-1:0] Q_HI = 2'b11;

endpackage

// File: rtl/logicnet_input_quantizer_if.sv
// Feature stream in, packed sample out; slave is the quantizer's view.
interface logicnet_input_quantizer_if
  import lnet_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int NUM_FEAT = 16
) ();

  logic                         s_valid;
  logic                         s_ready;
  logic signed [IN_W-1:0]       s_data;
  logic                         s_last;
  logic                         m_valid;
  logic                         m_ready;
  logic [CODE_W*NUM_FEAT-1:0]   m_data;

  modport slave  (input  s_valid, s_data, s_last, m_ready,
                  output s_ready, m_valid, m_data);
  modport master (output s_valid, s_data, s_last, m_ready,
                  input  s_ready, m_valid, m_data);

endinterface

// File: rtl/lnet_thresh_quant.sv
// Combinational three-threshold quantizer for one signed feature word.
module lnet_thresh_quant
  import lnet_pkg::*;
#(
  parameter int IN_W = 16
) (
  input  logic signed [IN_W-1:0] i_x,
  input  logic signed [IN_W-1:0] i_t0,
  input  logic signed [IN_W-1:0] i_t1,
  input  logic signed [IN_W-1:0] i_t2,
  output logic [CODE_W-1:0]      o_code
);

  always_comb begin
    o_code = Q_HI;
    if (i_x < i_t0)      o_code = Q_LO;
    else if (i_x < i_t1) o_code = Q_ML;
    else if (i_x < i_t2) o_code = Q_MH;
  end

endmodule

// File: rtl/logicnet_input_quantizer.sv
// Quantizes a feature stream to 2-bit codes and packs NUM_FEAT of them per sample.
// LNET_THRESH_PROG_EN adds a cfg write port for the three thresholds.
//   state   | meaning
//   COLLECT | accepting beats into pack slots
//   HOLD    | sample complete, input stalled until m_ready
//   DRAIN   | sample complete (too long), dropping beats up to s_last
module logicnet_input_quantizer
  import lnet_pkg::*;
#(
  parameter int                   NUM_FEAT = 16,
  parameter int                   IN_W     = 16,
  parameter logic signed [IN_W-1:0] T0     = IN_W'(-256),
  parameter logic signed [IN_W-1:0] T1     = IN_W'(0),
  parameter logic signed [IN_W-1:0] T2     = IN_W'(256)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  logicnet_input_quantizer_if.slave bus,
  output logic                      frame_err
`ifdef LNET_THRESH_PROG_EN
  ,
  input  logic                      cfg_we,
  input  logic [1:0]                cfg_sel,
  input  logic signed [IN_W-1:0]    cfg_wdata
`endif
);

  localparam int CNT_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_FEAT - 1);

  state_t                     r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic [CODE_W*NUM_FEAT-1:0] r_pack;
  logic                       r_s_ready;
  logic                       r_m_valid;
  logic                       r_frame_err;
  logic                       r_taken;
  logic                       r_last_seen;

  logic signed [IN_W-1:0]     w_t0, w_t1, w_t2;
  logic [CODE_W-1:0]          w_code;
  logic                       w_accept;

`ifdef LNET_THRESH_PROG_EN
  logic signed [IN_W-1:0] r_t0, r_t1, r_t2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t0 <= T0;
      r_t1 <= T1;
      r_t2 <= T2;
    end else if (cfg_we) begin
      case (cfg_sel)
        2'd0:    r_t0 <= cfg_wdata;
        2'd1:    r_t1 <= cfg_wdata;
        2'd2:    r_t2 <= cfg_wdata;
        default: ;
      endcase
    end
  end

  assign w_t0 = r_t0;
  assign w_t1 = r_t1;
  assign w_t2 = r_t2;
`else
  assign w_t0 = T0;
  assign w_t1 = T1;
  assign w_t2 = T2;
`endif

  lnet_thresh_quant #(.IN_W(IN_W)) u_quant (
    .i_x    (bus.s_data),
    .i_t0   (w_t0),
    .i_t1   (w_t1),
    .i_t2   (w_t2),
    .o_code (w_code)
  );

  assign w_accept    = bus.s_valid & r_s_ready;
  assign bus.s_ready = r_s_ready;
  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = r_pack;
  assign frame_err   = r_frame_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= COLLECT;
      r_cnt       <= '0;
      r_pack      <= '0;
      r_s_ready   <= 1'b1;
      r_m_valid   <= 1'b0;
      r_frame_err <= 1'b0;
      r_taken     <= 1'b0;
      r_last_seen <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        COLLECT: begin
          if (w_accept) begin
            // Unwritten slots are already zero: the pack register is cleared on every sample exit.
            r_pack[{r_cnt, 1'b0} +: CODE_W] <= w_code;
            if (bus.s_last) begin
              r_state     <= HOLD;
              r_s_ready   <= 1'b0;
              r_m_valid   <= 1'b1;
              r_frame_err <= (r_cnt != CNT_LAST);
            end else if (r_cnt == CNT_LAST) begin
              r_state     <= DRAIN;
              r_m_valid   <= 1'b1;
              r_frame_err <= 1'b1;
              r_taken     <= 1'b0;
              r_last_seen <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.m_ready) begin
            r_state   <= COLLECT;
            r_cnt     <= '0;
            r_pack    <= '0;
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b1;
          end
        end
        DRAIN: begin
          // Exit needs both the sample delivered and the terminating s_last, in either order.
          if ((r_taken || bus.m_ready) && (r_last_seen || (bus.s_valid && bus.s_last))) begin
            r_state     <= COLLECT;
            r_cnt       <= '0;
            r_pack      <= '0;
            r_m_valid   <= 1'b0;
            r_taken     <= 1'b0;
            r_last_seen <= 1'b0;
          end else begin
            if (bus.m_ready) begin
              r_taken   <= 1'b1;
              r_m_valid <= 1'b0;
            end
            if (bus.s_valid && bus.s_last) r_last_seen <= 1'b1;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

endmodule
